sync_fifo_param: RTL and testbench

Parametrised synchronous FIFO: next-generation storage block of the FIFO verification environment, replacing the fixed-geometry FIFO. Adds generic width/depth (non-power-of-two depths allowed), an exported occupancy count, run-time programmable full/empty thresholds and a synchronous flush. Status pulses (wr_ack, overflow, underflow) and static flags keep the existing semantics so the current assertion set and scoreboard carry over.

---
 rtl/sync_fifo_param_if.sv | 36 +++
 rtl/sync_fifo_param.sv | 109 ++++++++++
 tb/tb_sync_fifo_param.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/sync_fifo_param_if.sv
// rtl/sync_fifo_param_if.sv - request/status bundle for the parametrised synchronous FIFO
interface sync_fifo_param_if #(
    parameter int DATA_WIDTH = 16,
    parameter int FIFO_DEPTH = 8,
    parameter int CNT_W      = $clog2(FIFO_DEPTH + 1)
);
    logic                  flush;
    logic                  wr_en;
    logic [DATA_WIDTH-1:0] data_in;
    logic                  rd_en;
    logic [CNT_W-1:0]      af_thresh;
    logic [CNT_W-1:0]      ae_thresh;
    logic [DATA_WIDTH-1:0] data_out;
    logic                  wr_ack;
    logic                  overflow;
    logic                  underflow;
    logic [CNT_W-1:0]      count;
    logic                  full;
    logic                  empty;
    logic                  almostfull;
    logic                  almostempty;
    logic                  prog_full;
    logic                  prog_empty;

    modport master (
        output flush, wr_en, data_in, rd_en, af_thresh, ae_thresh,
        input  data_out, wr_ack, overflow, underflow, count,
        input  full, empty, almostfull, almostempty, prog_full, prog_empty
    );

    modport slave (
        input  flush, wr_en, data_in, rd_en, af_thresh, ae_thresh,
        output data_out, wr_ack, overflow, underflow, count,
        output full, empty, almostfull, almostempty, prog_full, prog_empty
    );
endinterface

// File: rtl/sync_fifo_param.sv
// rtl/sync_fifo_param.sv - synchronous FIFO with generic geometry, occupancy count and programmable thresholds
module sync_fifo_param #(
    parameter int DATA_WIDTH = 16,
    parameter int FIFO_DEPTH = 8,
    parameter int CNT_W      = $clog2(FIFO_DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    sync_fifo_param_if.slave bus
);
    localparam int PTR_W = (FIFO_DEPTH > 2) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(FIFO_DEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);

    logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];

    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
    logic                  wr_ack_q, wr_ack_d;
    logic                  overflow_q, overflow_d;
    logic                  underflow_q, underflow_d;

    logic full_w;
    logic empty_w;
    logic wr_accept;
    logic rd_accept;

    // Static flags are pure decodes of the current occupancy
    assign full_w  = (count_q == CNT_FULL);
    assign empty_w = (count_q == '0);

    // Acceptance looks only at this cycle's flags; flush blocks both sides
    assign wr_accept = bus.wr_en && !full_w  && !bus.flush;
    assign rd_accept = bus.rd_en && !empty_w && !bus.flush;

    // Next-state for pointers, occupancy, read data and status pulses
    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        data_out_d  = data_out_q;
        wr_ack_d    = wr_accept;
        overflow_d  = bus.wr_en && full_w  && !bus.flush;
        underflow_d = bus.rd_en && empty_w && !bus.flush;

        if (bus.flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            // Pointers wrap by compare so non-power-of-two depths work
            if (wr_accept) begin
                wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + PTR_W'(1);
            end
            if (rd_accept) begin
                rd_ptr_d   = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + PTR_W'(1);
                data_out_d = mem_q[rd_ptr_q];
            end
            case ({wr_accept, rd_accept})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Control and status registers with asynchronous clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            data_out_q  <= '0;
            wr_ack_q    <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            data_out_q  <= data_out_d;
            wr_ack_q    <= wr_ack_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Storage array is deliberately left out of reset
    always_ff @(posedge clk) begin
        if (wr_accept) begin
            mem_q[wr_ptr_q] <= bus.data_in;
        end
    end

    assign bus.data_out    = data_out_q;
    assign bus.wr_ack      = wr_ack_q;
    assign bus.overflow    = overflow_q;
    assign bus.underflow   = underflow_q;
    assign bus.count       = count_q;
    assign bus.full        = full_w;
    assign bus.empty       = empty_w;
    assign bus.almostfull  = (count_q == CNT_W'(FIFO_DEPTH - 1));
    assign bus.almostempty = (count_q == CNT_W'(1));
    // Thresholds beyond the depth simply never match prog_full
    assign bus.prog_full   = (count_q >= bus.af_thresh);
    assign bus.prog_empty  = (count_q <= bus.ae_thresh);
endmodule

// File: tb/tb_sync_fifo_param.sv
// tb/tb_sync_fifo_param.sv - scoreboard bench for sync_fifo_param at depth 6, width 16
module tb_sync_fifo_param;
    localparam int W = 16;
    localparam int D = 6;
    localparam int C = $clog2(D + 1);

    typedef struct packed {
        logic [W-1:0] dout;
        logic         ack;
        logic         ovf;
        logic         udf;
        logic [C-1:0] cnt;
        logic         full;
        logic         empty;
        logic         afl;
        logic         aem;
        logic         pf;
        logic         pe;
    } obs_t;

    logic clk = 1'b0;
    logic rst_n;
    int   n_tests = 0;
    int   n_fail  = 0;

    obs_t         exp_q[$];
    logic [W-1:0] mq[$];
    logic [W-1:0] m_dout;
    logic         m_ack, m_ovf, m_udf;
    logic [C-1:0] af_r, ae_r;
    logic [W-1:0] held;

    sync_fifo_param_if #(.DATA_WIDTH(W), .FIFO_DEPTH(D)) bus ();

    sync_fifo_param #(.DATA_WIDTH(W), .FIFO_DEPTH(D)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    function automatic obs_t snap_dut();
        obs_t a;
        a = '{bus.data_out, bus.wr_ack, bus.overflow, bus.underflow, bus.count,
              bus.full, bus.empty, bus.almostfull, bus.almostempty,
              bus.prog_full, bus.prog_empty};
        return a;
    endfunction

    function automatic obs_t model_obs();
        obs_t e;
        int   n;
        n = mq.size();
        e.dout  = m_dout;
        e.ack   = m_ack;
        e.ovf   = m_ovf;
        e.udf   = m_udf;
        e.cnt   = C'(n);
        e.full  = (n == D);
        e.empty = (n == 0);
        e.afl   = (n == D - 1);
        e.aem   = (n == 1);
        e.pf    = (n >= int'(af_r));
        e.pe    = (n <= int'(ae_r));
        return e;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    // Monitor: every cycle that had stimulus has exactly one expected record queued
    always @(posedge clk) begin
        obs_t a, e;
        #2;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = snap_dut();
            n_tests++;
            if (a !== e) begin
                n_fail++;
                $display("FAIL scoreboard @%0t: got %h, expected %h", $time, a, e);
            end
        end
    end

    // One clock of stimulus; the reference queue predicts the post-edge view
    task automatic step(input logic w, input logic [W-1:0] d, input logic r, input logic fl);
        logic full_now, empty_now;
        @(negedge clk);
        bus.wr_en     = w;
        bus.data_in   = d;
        bus.rd_en     = r;
        bus.flush     = fl;
        bus.af_thresh = af_r;
        bus.ae_thresh = ae_r;
        full_now  = (mq.size() == D);
        empty_now = (mq.size() == 0);
        if (fl) begin
            mq.delete();
            m_ack = 1'b0;
            m_ovf = 1'b0;
            m_udf = 1'b0;
        end else begin
            if (r && !empty_now) m_dout = mq.pop_front();
            if (w && !full_now) mq.push_back(d);
            m_ack = w && !full_now;
            m_ovf = w && full_now;
            m_udf = r && empty_now;
        end
        exp_q.push_back(model_obs());
        @(posedge clk);
        #3;
        bus.wr_en = 1'b0;
        bus.rd_en = 1'b0;
        bus.flush = 1'b0;
    endtask

    task automatic model_reset();
        mq.delete();
        m_dout = '0;
        m_ack  = 1'b0;
        m_ovf  = 1'b0;
        m_udf  = 1'b0;
    endtask

    initial begin
        rst_n         = 1'b0;
        bus.flush     = 1'b0;
        bus.wr_en     = 1'b0;
        bus.rd_en     = 1'b0;
        bus.data_in   = '0;
        af_r          = '0;
        ae_r          = 3'd1;
        bus.af_thresh = af_r;
        bus.ae_thresh = ae_r;
        model_reset();

        #1;
        chk("rst_count", 32'(bus.count), 0);
        chk("rst_empty", 32'(bus.empty), 1);
        chk("rst_full", 32'(bus.full), 0);
        chk("rst_almostfull", 32'(bus.almostfull), 0);
        chk("rst_almostempty", 32'(bus.almostempty), 0);
        chk("rst_prog_empty", 32'(bus.prog_empty), 1);
        chk("rst_prog_full_af0", 32'(bus.prog_full), 1);
        chk("rst_data_out", 32'(bus.data_out), 0);
        chk("rst_pulses", 32'({bus.wr_ack, bus.overflow, bus.underflow}), 0);
        af_r          = 3'd7;
        bus.af_thresh = af_r;
        #1;
        chk("rst_prog_full_af7", 32'(bus.prog_full), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Fill 0x0001..0x0006, then one write too many
        for (int i = 1; i <= D; i++) begin
            step(1'b1, W'(i), 1'b0, 1'b0);
            chk("fill_count", 32'(bus.count), 32'(i));
            chk("fill_ack", 32'(bus.wr_ack), 1);
        end
        chk("fill_full", 32'(bus.full), 1);
        step(1'b1, 16'h0007, 1'b0, 1'b0);
        chk("ovf_pulse", 32'(bus.overflow), 1);
        chk("ovf_count", 32'(bus.count), 6);

        // Drain in order, then one read too many
        for (int i = 1; i <= D; i++) begin
            step(1'b0, '0, 1'b1, 1'b0);
            chk("drain_data", 32'(bus.data_out), 32'(i));
        end
        chk("drain_empty", 32'(bus.empty), 1);
        step(1'b0, '0, 1'b1, 1'b0);
        chk("udf_pulse", 32'(bus.underflow), 1);
        chk("udf_hold", 32'(bus.data_out), 32'h0006);

        // Simultaneous read+write at empty, mid-level and full
        step(1'b1, 16'h00AA, 1'b1, 1'b0);
        chk("sim_empty_count", 32'(bus.count), 1);
        chk("sim_empty_udf", 32'(bus.underflow), 1);
        step(1'b1, 16'h00BB, 1'b0, 1'b0);
        step(1'b1, 16'h00CC, 1'b0, 1'b0);
        step(1'b1, 16'h00DD, 1'b1, 1'b0);
        chk("sim_mid_count", 32'(bus.count), 3);
        chk("sim_mid_ack", 32'(bus.wr_ack), 1);
        chk("sim_mid_data", 32'(bus.data_out), 32'h00AA);
        for (int i = 0; i < 3; i++) step(1'b1, 16'h0100 + W'(i), 1'b0, 1'b0);
        step(1'b1, 16'h0EEE, 1'b1, 1'b0);
        chk("sim_full_count", 32'(bus.count), 5);
        chk("sim_full_ovf", 32'(bus.overflow), 1);
        chk("sim_full_data", 32'(bus.data_out), 32'h00BB);

        // Random interleaving exercises pointer wrap on a non-power-of-two depth
        for (int i = 0; i < 40; i++) begin
            step(1'($urandom_range(0, 1)), W'($urandom), 1'($urandom_range(0, 1)), 1'b0);
        end
        while (mq.size() > 0) step(1'b0, '0, 1'b1, 1'b0);

        // Programmable thresholds
        af_r = 3'd4;
        ae_r = 3'd1;
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 16'h0200 + W'(i), 1'b0, 1'b0);
            chk("pf_rise", 32'(bus.prog_full), (i == 3) ? 1 : 0);
        end
        for (int i = 0; i < 3; i++) begin
            step(1'b0, '0, 1'b1, 1'b0);
            chk("pe_rise", 32'(bus.prog_empty), (i == 2) ? 1 : 0);
        end
        step(1'b1, 16'h0210, 1'b0, 1'b0);
        step(1'b1, 16'h0211, 1'b0, 1'b0);
        chk("pf_at3_af4", 32'(bus.prog_full), 0);
        @(negedge clk);
        af_r          = 3'd2;
        bus.af_thresh = af_r;
        #1;
        chk("pf_af_change", 32'(bus.prog_full), 1);

        // Flush at count 4 with a concurrent write
        step(1'b1, 16'h0212, 1'b0, 1'b0);
        chk("pre_flush_count", 32'(bus.count), 4);
        held = bus.data_out;
        step(1'b1, 16'h0555, 1'b0, 1'b1);
        chk("flush_count", 32'(bus.count), 0);
        chk("flush_empty", 32'(bus.empty), 1);
        chk("flush_ack", 32'(bus.wr_ack), 0);
        chk("flush_data_hold", 32'(bus.data_out), 32'(held));

        // Asynchronous reset in the middle of a write at count 3
        for (int i = 0; i < 3; i++) step(1'b1, 16'h0300 + W'(i), 1'b0, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0);
        step(1'b1, 16'h0303, 1'b0, 1'b0);
        chk("pre_rst_count", 32'(bus.count), 3);
        @(negedge clk);
        bus.wr_en   = 1'b1;
        bus.data_in = 16'h0BAD;
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_count", 32'(bus.count), 0);
        chk("arst_empty", 32'(bus.empty), 1);
        chk("arst_data", 32'(bus.data_out), 0);
        chk("arst_pulses", 32'({bus.wr_ack, bus.overflow, bus.underflow}), 0);
        model_reset();
        @(negedge clk);
        bus.wr_en = 1'b0;
        rst_n     = 1'b1;
        step(1'b1, 16'h0042, 1'b1, 1'b0);
        chk("post_rst_count", 32'(bus.count), 1);
        chk("post_rst_udf", 32'(bus.underflow), 1);
        step(1'b0, '0, 1'b1, 1'b0);
        chk("post_rst_data", 32'(bus.data_out), 32'h0042);

        @(negedge clk);
        chk("scoreboard_drained", 32'(exp_q.size()), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
